// File: rtl/hazard_ctrl.sv
// Hazard unit for the five-stage pentaRV pipeline: forwarding, load-use bubble,
// branch flush and slow-memory freeze. Performance counters exist only with HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 0,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic                  useRs1D,
  input  logic                  useRs2D,
  input  logic [REG_ADDR_W-1:0] rs1E,
  input  logic [REG_ADDR_W-1:0] rs2E,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  PCsrcE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  RegWriteW,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushW,
  output logic [1:0]            fwdAE,
  output logic [1:0]            fwdBE,
  output logic [CNT_W-1:0]      stallCycles,
  output logic [CNT_W-1:0]      flushEvents,
  output logic [CNT_W-1:0]      fwdEvents,
  output logic [1:0]            memStateDbg
);

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_WAIT    = 2'd1,
    MEM_RELEASE = 2'd2
  } memState_t;

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  logic [2:0] cnt;
  logic [2:0] cntNext;
  memState_t  memState;

  logic       ldM;
  logic       lu;
  logic       rawMemStall;
  logic       rawStallFD;
  logic       rawFlushBr;
  logic       rawFlushE;
  logic [1:0] rawFwdA;
  logic [1:0] rawFwdB;

  assign ldM = MemtoRegM & RegWriteM;

  // Forwarding: M beats W; a load in M has no ALU result to forward.
  always_comb begin
    rawFwdA = 2'b00;
    if (RegWriteM && (rdM != '0) && (rdM == rs1E) && !MemtoRegM)
      rawFwdA = 2'b10;
    else if (RegWriteW && (rdW != '0) && (rdW == rs1E))
      rawFwdA = 2'b01;
  end

  always_comb begin
    rawFwdB = 2'b00;
    if (RegWriteM && (rdM != '0) && (rdM == rs2E) && !MemtoRegM)
      rawFwdB = 2'b10;
    else if (RegWriteW && (rdW != '0) && (rdW == rs2E))
      rawFwdB = 2'b01;
  end

  assign lu = MemtoRegE & RegWriteE & (rdE != '0) &
              ((useRs1D & (rdE == rs1D)) | (useRs2D & (rdE == rs2D)));

  // Memory wait FSM: cnt is the whole state; the phase is decoded from cnt and ldM.
  always_comb begin
    memState = MEM_IDLE;
    cntNext  = '0;
    if (ldM) begin
      if (cnt < LAT) begin
        memState = MEM_WAIT;
        cntNext  = cnt + 3'd1;
      end else begin
        memState = MEM_RELEASE;
        cntNext  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cntNext;
  end

  // While memory freezes the pipe, E is held, so branch and load-use resolve after release.
  assign rawMemStall = (memState == MEM_WAIT);
  assign rawStallFD  = rawMemStall | (lu & ~PCsrcE);
  assign rawFlushBr  = PCsrcE & ~rawMemStall;
  assign rawFlushE   = (PCsrcE | lu) & ~rawMemStall;

  assign stallF      = rst & rawStallFD;
  assign stallD      = rst & rawStallFD;
  assign stallE      = rst & rawMemStall;
  assign stallM      = rst & rawMemStall;
  assign flushD      = rst & rawFlushBr;
  assign flushE      = rst & rawFlushE;
  assign flushW      = rst & rawMemStall;
  assign fwdAE       = rst ? rawFwdA : 2'b00;
  assign fwdBE       = rst ? rawFwdB : 2'b00;
  assign memStateDbg = rst ? memState : MEM_IDLE;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [CNT_W-1:0] fwdCnt;

  // Saturating counters; increments use the ungated terms since rst is high here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (rawStallFD && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if (rawFlushBr && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
      if (((rawFwdA != 2'b00) || (rawFwdB != 2'b00)) && (fwdCnt != '1))
        fwdCnt <= fwdCnt + CNT_W'(1);
    end
  end

  assign stallCycles = stallCnt;
  assign flushEvents = flushCnt;
  assign fwdEvents   = fwdCnt;
`else
  assign stallCycles = '0;
  assign flushEvents = '0;
  assign fwdEvents   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with LOAD_LAT=2 and CNT_W=4: vector table for the
// combinational paths, hand sequences for load waits, reset mid-wait and counters.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          useRs1D, useRs2D, RegWriteE, MemtoRegE, PCsrcE;
  logic          RegWriteM, MemtoRegM, RegWriteW;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0]    fwdAE, fwdBE, memStateDbg;
  logic [CW-1:0] stallCycles, flushEvents, fwdEvents;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_LAT(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCsrcE(PCsrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .rdW(rdW), .RegWriteW(RegWriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .fwdAE(fwdAE), .fwdBE(fwdBE),
    .stallCycles(stallCycles), .flushEvents(flushEvents), .fwdEvents(fwdEvents),
    .memStateDbg(memStateDbg)
  );

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE}
  logic [10:0] obs;
  assign obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rs1D, rs2D;
    logic          useRs1D, useRs2D;
    logic [AW-1:0] rs1E, rs2E, rdE;
    logic          RegWriteE, MemtoRegE, PCsrcE;
    logic [AW-1:0] rdM;
    logic          RegWriteM, MemtoRegM;
    logic [AW-1:0] rdW;
    logic          RegWriteW;
    logic [10:0]   exp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [AW-1:0] a1D, input logic [AW-1:0] a2D, input logic u1, input logic u2,
    input logic [AW-1:0] a1E, input logic [AW-1:0] a2E, input logic [AW-1:0] dE,
    input logic rwE, input logic mrE, input logic pc,
    input logic [AW-1:0] dM, input logic rwM, input logic mrM,
    input logic [AW-1:0] dW, input logic rwW, input logic [10:0] e);
    vec_t v;
    v.rs1D = a1D; v.rs2D = a2D; v.useRs1D = u1; v.useRs2D = u2;
    v.rs1E = a1E; v.rs2E = a2E; v.rdE = dE;
    v.RegWriteE = rwE; v.MemtoRegE = mrE; v.PCsrcE = pc;
    v.rdM = dM; v.RegWriteM = rwM; v.MemtoRegM = mrM;
    v.rdW = dW; v.RegWriteW = rwW; v.exp = e;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    rs1D = v.rs1D; rs2D = v.rs2D; useRs1D = v.useRs1D; useRs2D = v.useRs2D;
    rs1E = v.rs1E; rs2E = v.rs2E; rdE = v.rdE;
    RegWriteE = v.RegWriteE; MemtoRegE = v.MemtoRegE; PCsrcE = v.PCsrcE;
    rdM = v.rdM; RegWriteM = v.RegWriteM; MemtoRegM = v.MemtoRegM;
    rdW = v.rdW; RegWriteW = v.RegWriteW;
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; useRs1D = 0; useRs2D = 0;
    rs1E = '0; rs2E = '0; rdE = '0;
    RegWriteE = 0; MemtoRegE = 0; PCsrcE = 0;
    rdM = '0; RegWriteM = 0; MemtoRegM = 0;
    rdW = '0; RegWriteW = 0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // Fields: rs1D rs2D u1 u2 rs1E rs2E rdE rwE mrE pc rdM rwM mrM rdW rwW exp
    vecs[0]  = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 11'b0000000_00_00);
    vecs[1]  = mk(0,0,0,0, 5,0,0, 0,0,0, 5,1,0, 5,1, 11'b0000000_10_00);
    vecs[2]  = mk(0,0,0,0, 5,0,0, 0,0,0, 0,1,0, 5,1, 11'b0000000_01_00);
    vecs[3]  = mk(0,0,0,0, 7,7,0, 0,0,0, 7,1,0, 0,0, 11'b0000000_10_10);
    vecs[4]  = mk(0,0,0,0, 0,6,0, 0,0,0, 6,0,0, 6,1, 11'b0000000_00_01);
    vecs[5]  = mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,0, 0,1, 11'b0000000_00_00);
    vecs[6]  = mk(0,3,0,1, 0,0,3, 1,1,0, 0,0,0, 0,0, 11'b1100010_00_00);
    vecs[7]  = mk(0,3,0,0, 0,0,3, 1,1,0, 0,0,0, 0,0, 11'b0000000_00_00);
    vecs[8]  = mk(3,0,1,0, 0,0,3, 1,1,0, 0,0,0, 0,0, 11'b1100010_00_00);
    vecs[9]  = mk(0,0,1,0, 0,0,0, 1,1,0, 0,0,0, 0,0, 11'b0000000_00_00);
    vecs[10] = mk(0,3,0,1, 0,0,3, 1,1,1, 0,0,0, 0,0, 11'b0000110_00_00);
    vecs[11] = mk(0,0,0,0, 0,0,0, 0,0,1, 0,0,0, 0,0, 11'b0000110_00_00);
    vecs[12] = mk(0,3,0,1, 0,0,3, 1,0,0, 0,0,0, 0,0, 11'b0000000_00_00);
    vecs[13] = mk(0,3,0,1, 0,0,3, 0,1,0, 0,0,0, 0,0, 11'b0000000_00_00);
    vecs[14] = mk(0,3,0,1, 5,0,3, 1,1,0, 0,0,0, 5,1, 11'b1100010_01_00);

    // Reset with forwarding-worthy inputs: outputs must stay zero.
    rst = 1'b0;
    clear_inputs();
    rs1E = 5; rdW = 5; RegWriteW = 1; PCsrcE = 1;
    #1;
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_counters", {20'd0, stallCycles, flushEvents, fwdEvents}, 32'd0);
    check("reset_state", 32'(memStateDbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // Two back-to-back loads with a taken branch held in E; the load in M must not forward.
    @(negedge clk);
    clear_inputs();
    MemtoRegM = 1; RegWriteM = 1; rdM = 4;
    rs1E = 4; rdW = 4; RegWriteW = 1; PCsrcE = 1;
    for (int i = 0; i < 6; i++) begin
      logic s;
      s = ((i % 3) != 2);
      #1;
      check($sformatf("load_cyc%0d", i), 32'(obs),
            32'({s, s, s, s, ~s, ~s, s, 2'b01, 2'b00}));
      check($sformatf("load_state%0d", i), 32'(memStateDbg), s ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    clear_inputs();

    // Reset asserted while cnt=1, then a fresh load waits the full latency.
    @(negedge clk);
    MemtoRegM = 1; RegWriteM = 1; rdM = 4;
    @(negedge clk);
    #1;
    check("midwait_stallM", 32'(stallM), 32'd1);
    rs1E = 9; rdW = 9; RegWriteW = 1; PCsrcE = 1;
    rdE = 3; MemtoRegE = 1; RegWriteE = 1; rs2D = 3; useRs2D = 1;
    rst = 1'b0;
    #1;
    check("midwait_rst_outputs", 32'(obs), 32'd0);
    check("midwait_rst_counters", {20'd0, stallCycles, flushEvents, fwdEvents}, 32'd0);
    @(negedge clk);
    clear_inputs();
    MemtoRegM = 1; RegWriteM = 1; rdM = 4;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("postrst_stallM%0d", i), 32'(stallM), (i < 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    clear_inputs();

    // Counters: clear, hold a load-use stall for 20 cycles, then branch for 3.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    rdE = 3; MemtoRegE = 1; RegWriteE = 1; rs2D = 3; useRs2D = 1;
    repeat (20) @(negedge clk);
`ifdef HAZARD_PERF_EN
    check("stallCycles_sat", 32'(stallCycles), 32'd15);
    check("flushEvents_lu", 32'(flushEvents), 32'd0);
    check("fwdEvents_none", 32'(fwdEvents), 32'd0);
`else
    check("stallCycles_off", 32'(stallCycles), 32'd0);
    check("flushEvents_off", 32'(flushEvents), 32'd0);
    check("fwdEvents_off", 32'(fwdEvents), 32'd0);
`endif
    clear_inputs();
    PCsrcE = 1;
    rs1E = 5; rdW = 5; RegWriteW = 1;
    repeat (3) @(negedge clk);
`ifdef HAZARD_PERF_EN
    check("flushEvents_br", 32'(flushEvents), 32'd3);
    check("fwdEvents_br", 32'(fwdEvents), 32'd3);
`else
    check("flushEvents_br_off", 32'(flushEvents), 32'd0);
    check("fwdEvents_br_off", 32'(fwdEvents), 32'd0);
`endif
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
